// File: rtl/fifo_pkg.sv
// Shared definitions for the ring-buffer FIFO.
//   fifo_status_t : status bundle {empty, full, almost_full, overflow, underflow}
//   cnt_w()       : occupancy counter width, $clog2(depth+1)
//   ptr_w()       : pointer width for a depth-entry array (at least 1)
//   ptr_next()    : pointer increment with an explicit wrap depth-1 -> 0
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Compare against depth-1 rather than relying on natural overflow, so
    // non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register for the ring-buffer FIFO.
//   clk   : clock, updates on rising edge
//   rst_n : asynchronous active-low reset, pointer -> 0
//   clr   : synchronous clear, pointer -> 0 (wins over en)
//   en    : advance pointer by one, wrapping DEPTH-1 -> 0
//   ptr   : current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    output logic [ptr_w(DEPTH)-1:0]      ptr
);

    localparam int unsigned PW = ptr_w(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= PW'(ptr_next(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/fifo_ring.sv
// Parametrised circular-buffer FIFO with show-ahead output.
//   clk         : clock, all state updates on rising edge
//   rst_n       : asynchronous active-low reset
//   clr         : synchronous flush of pointers, count and error flags
//   push, d     : write d when accepted
//   pop         : consume the head entry when accepted
//   q           : head entry, zero when empty
//   count       : occupancy 0..DEPTH
//   empty/full/almost_full : decoded from count
//   overflow    : sticky, a push was rejected because the FIFO was full
//   underflow   : sticky, a pop was attempted while empty
module fifo_ring
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BITS     = 64,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [BITS-1:0]              d,
    input  logic                         pop,
    output logic [BITS-1:0]              q,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_r;
    logic            ovf_r;
    logic            unf_r;
    logic            push_ok;
    logic            pop_ok;
    fifo_status_t    st;

    always_comb begin
        st             = '0;
        st.empty       = (cnt_r == '0);
        st.full        = (32'(cnt_r) == DEPTH);
        st.almost_full = (32'(cnt_r) >= AF_LEVEL);
        st.overflow    = ovf_r;
        st.underflow   = unf_r;
    end

    // A flush cycle suppresses both handshakes. A push into a full FIFO is
    // still accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        pop_ok  = pop & ~st.empty & ~clr;
        push_ok = push & ~clr & (~st.full | pop_ok);
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (pop_ok),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately not reset; the empty gate on q hides stale data.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (clr) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            cnt_r <= cnt_r + CW'(push_ok) - CW'(pop_ok);
            if (push && !push_ok) begin
                ovf_r <= 1'b1;
            end
            if (pop && st.empty) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign q           = st.empty ? '0 : mem[rd_ptr];
    assign count       = cnt_r;
    assign empty       = st.empty;
    assign full        = st.full;
    assign almost_full = st.almost_full;
    assign overflow    = st.overflow;
    assign underflow   = st.underflow;

endmodule

// File: tb/tb_fifo_ring.sv
// Testbench for fifo_ring: a DEPTH=8 instance for directed scenarios and a
// DEPTH=5/AF_LEVEL=3 instance for a randomized run, both fed the same inputs
// and checked against a queue-based reference model.
module tb_fifo_ring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [63:0] d = '0;

    logic [63:0] q8, q5;
    logic [3:0]  cnt8;
    logic [2:0]  cnt5;
    logic        e8, f8, af8, ov8, un8;
    logic        e5, f5, af5, ov5, un5;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_ring #(.DEPTH(8), .BITS(64)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .d(d), .pop(pop),
        .q(q8), .count(cnt8), .empty(e8), .full(f8), .almost_full(af8),
        .overflow(ov8), .underflow(un8)
    );

    fifo_ring #(.DEPTH(5), .BITS(64), .AF_LEVEL(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .d(d), .pop(pop),
        .q(q5), .count(cnt5), .empty(e5), .full(f5), .almost_full(af5),
        .overflow(ov5), .underflow(un5)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of live entries plus two sticky flags.
    typedef logic [63:0] dq_t[$];
    dq_t m8, m5;
    bit  mo8, mu8, mo5, mu5;

    task automatic mstep(inout dq_t m, inout bit ov, inout bit un, input int depth);
        bit pok, wok;
        if (clr) begin
            m.delete();
            ov = 1'b0;
            un = 1'b0;
        end else begin
            pok = pop && (m.size() > 0);
            wok = push && ((m.size() < depth) || pok);
            if (pop && m.size() == 0) un = 1'b1;
            if (push && !wok) ov = 1'b1;
            if (pok) void'(m.pop_front());
            if (wok) m.push_back(d);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8.delete(); m5.delete();
            mo8 = 1'b0; mu8 = 1'b0; mo5 = 1'b0; mu5 = 1'b0;
        end else begin
            mstep(m8, mo8, mu8, 8);
            mstep(m5, mo5, mu5, 5);
        end
    end

    function automatic logic [63:0] head(input dq_t m);
        return (m.size() > 0) ? m[0] : 64'h0;
    endfunction

    // Inputs change only at the falling edge; outputs are read there too.
    task automatic drive(input bit pu, input bit po, input logic [63:0] dd);
        push = pu; pop = po; d = dd;
        @(negedge clk);
    endtask

    task automatic do_clr();
        push = 1'b0; pop = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({q8, cnt8, e8, f8, af8, ov8, un8} !== {64'h0, 4'd0, 1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_hold: got q=%h cnt=%0d e/f/af/ov/un=%b%b%b%b%b want q=0 cnt=0 10000",
                     q8, cnt8, e8, f8, af8, ov8, un8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({q8, cnt8, e8, f8, af8, ov8, un8} !== {64'h0, 4'd0, 1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_idle: got q=%h cnt=%0d e/f/af/ov/un=%b%b%b%b%b want q=0 cnt=0 10000",
                     q8, cnt8, e8, f8, af8, ov8, un8);
        end
        drive(1, 0, 64'h5A);
        drive(1, 0, 64'h5B);
        push = 1'b0;
        n_cmp++;
        if (cnt8 !== 4'd2 || q8 !== 64'h5A) begin
            n_bad++;
            $display("FAIL pre_reset_fill: got cnt=%0d q=%h want cnt=2 q=5a", cnt8, q8);
        end
        // Assert reset while clk is high; outputs must react before the next edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({q8, cnt8, e8, f8} !== {64'h0, 4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got q=%h cnt=%0d empty=%b full=%b want q=0 cnt=0 empty=1 full=0",
                     q8, cnt8, e8, f8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 64'h0);
        pop = 1'b0;
        n_cmp++;
        if (un8 !== 1'b1 || cnt8 !== 4'd0 || q8 !== 64'h0) begin
            n_bad++;
            $display("FAIL post_reset_pop: got underflow=%b cnt=%0d q=%h want 1 0 0", un8, cnt8, q8);
        end
        do_clr();
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 8; k++) begin
            drive(1, 0, 64'(64'h11 * k));
            if (k == 7) begin
                n_cmp++;
                if (cnt8 !== 4'd7 || af8 !== 1'b1 || f8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fill_af: got cnt=%0d af=%b full=%b want 7 1 0", cnt8, af8, f8);
                end
            end
        end
        push = 1'b0;
        n_cmp++;
        if (cnt8 !== 4'd8 || f8 !== 1'b1 || af8 !== 1'b1 || e8 !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: got cnt=%0d full=%b af=%b empty=%b want 8 1 1 0", cnt8, f8, af8, e8);
        end
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if (q8 !== 64'(64'h11 * k)) begin
                n_bad++;
                $display("FAIL drain_q[%0d]: got %h want %h", k, q8, 64'(64'h11 * k));
            end
            drive(0, 1, 64'h0);
        end
        pop = 1'b0;
        n_cmp++;
        if (e8 !== 1'b1 || q8 !== 64'h0 || un8 !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: got empty=%b q=%h underflow=%b want 1 0 0", e8, q8, un8);
        end
    endtask

    task automatic test_full_stream();
        logic [63:0] expv;
        for (int i = 0; i < 8; i++) drive(1, 0, 64'(64'h100 + i));
        for (int i = 0; i < 20; i++) begin
            expv = (i < 8) ? 64'(64'h100 + i) : 64'(64'h200 + i - 8);
            n_cmp++;
            if (q8 !== expv) begin
                n_bad++;
                $display("FAIL stream_q[%0d]: got %h want %h", i, q8, expv);
            end
            drive(1, 1, 64'(64'h200 + i));
            n_cmp++;
            if (cnt8 !== 4'd8 || ov8 !== 1'b0 || f8 !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_cnt[%0d]: got cnt=%0d ovf=%b full=%b want 8 0 1", i, cnt8, ov8, f8);
            end
        end
        for (int i = 20; i < 28; i++) begin
            expv = 64'(64'h200 + i - 8);
            n_cmp++;
            if (q8 !== expv) begin
                n_bad++;
                $display("FAIL stream_tail[%0d]: got %h want %h", i, q8, expv);
            end
            drive(0, 1, 64'h0);
        end
        pop = 1'b0;
        n_cmp++;
        if (e8 !== 1'b1 || un8 !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_end: got empty=%b underflow=%b want 1 0", e8, un8);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 8; i++) drive(1, 0, 64'(64'hA0 + i));
        drive(1, 0, 64'hDEAD);
        push = 1'b0;
        n_cmp++;
        if (ov8 !== 1'b1 || cnt8 !== 4'd8 || q8 !== 64'hA0 || un8 !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow: got ovf=%b cnt=%0d q=%h unf=%b want 1 8 a0 0", ov8, cnt8, q8, un8);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q8 !== 64'(64'hA0 + i)) begin
                n_bad++;
                $display("FAIL ovf_contents[%0d]: got %h want %h", i, q8, 64'(64'hA0 + i));
            end
            drive(0, 1, 64'h0);
        end
        drive(0, 1, 64'h0);
        pop = 1'b0;
        n_cmp++;
        if (un8 !== 1'b1 || ov8 !== 1'b1 || e8 !== 1'b1 || cnt8 !== 4'd0) begin
            n_bad++;
            $display("FAIL underflow: got unf=%b ovf=%b empty=%b cnt=%0d want 1 1 1 0", un8, ov8, e8, cnt8);
        end
        do_clr();
        n_cmp++;
        if (cnt8 !== 4'd0 || ov8 !== 1'b0 || un8 !== 1'b0 || e8 !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_flags: got cnt=%0d ovf=%b unf=%b empty=%b want 0 0 0 1", cnt8, ov8, un8, e8);
        end
    endtask

    task automatic test_empty_pushpop();
        push = 1'b1; pop = 1'b1; d = 64'h42;
        #1;
        n_cmp++;
        if (q8 !== 64'h0 || e8 !== 1'b1) begin
            n_bad++;
            $display("FAIL no_fallthrough: got q=%h empty=%b want 0 1", q8, e8);
        end
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        n_cmp++;
        if (un8 !== 1'b1 || cnt8 !== 4'd1 || q8 !== 64'h42) begin
            n_bad++;
            $display("FAIL empty_pushpop: got unf=%b cnt=%0d q=%h want 1 1 42", un8, cnt8, q8);
        end
        do_clr();
    endtask

    task automatic test_random();
        int pp, qp, pushes5;
        logic [71:0] got5, exp5;
        logic [72:0] got8, exp8;
        pushes5 = 0;
        for (int c = 0; c < 1000; c++) begin
            case ((c / 100) % 3)
                0:       begin pp = 75; qp = 40; end
                1:       begin pp = 50; qp = 50; end
                default: begin pp = 30; qp = 75; end
            endcase
            clr  = ($urandom_range(127) == 0);
            push = ($urandom_range(99) < pp);
            pop  = ($urandom_range(99) < qp);
            d    = {$urandom, $urandom};
            @(negedge clk);
            got5 = {q5, cnt5, e5, f5, af5, ov5, un5};
            exp5 = {head(m5), 3'(m5.size()), m5.size() == 0, m5.size() == 5,
                    m5.size() >= 3, mo5, mu5};
            n_cmp++;
            if (got5 !== exp5) begin
                n_bad++;
                $display("FAIL rand5[%0d]: got q=%h cnt=%0d e/f/af/ov/un=%b want q=%h cnt=%0d e/f/af/ov/un=%b",
                         c, got5[71:8], got5[7:5], got5[4:0], exp5[71:8], exp5[7:5], exp5[4:0]);
            end
            got8 = {q8, cnt8, e8, f8, af8, ov8, un8};
            exp8 = {head(m8), 4'(m8.size()), m8.size() == 0, m8.size() == 8,
                    m8.size() >= 7, mo8, mu8};
            n_cmp++;
            if (got8 !== exp8) begin
                n_bad++;
                $display("FAIL rand8[%0d]: got q=%h cnt=%0d e/f/af/ov/un=%b want q=%h cnt=%0d e/f/af/ov/un=%b",
                         c, got8[72:9], got8[8:5], got8[4:0], exp8[72:9], exp8[8:5], exp8[4:0]);
            end
            if (push && !clr) pushes5++;
        end
        clr = 1'b0; push = 1'b0; pop = 1'b0;
        if (pushes5 < 10) $display("note: random run issued only %0d pushes", pushes5);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_stream();
        test_errors();
        test_empty_pushpop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
